// File: rtl/byte_seq_checker.sv
// Receive-side checker for an incrementing byte stream: seeds, locks, and flags sequence breaks.
// Optional BYTE_SEQ_CHECKER_HALT_EN: a break while locked freezes the checker in HALT until clr/rst_n.
module byte_seq_checker #(
  parameter int unsigned STEP      = 1,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [7:0]           in_byte,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [7:0]           exp_byte,
  output logic [15:0]          sample_cnt
);

  localparam int unsigned RUN_W = 4;
  localparam logic [7:0]       STEP_B   = 8'(STEP);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

`ifdef BYTE_SEQ_CHECKER_HALT_EN
  typedef enum logic [1:0] {IDLE, SYNC, LOCK, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;
`endif

  state_t           state;
  logic [RUN_W-1:0] run;
  logic [7:0]       nxt_byte;
  logic             match;

  assign nxt_byte = in_byte + STEP_B;
  assign match    = (in_byte == exp_byte);

  // Single registered FSM; clr acts like reset and swallows any same-cycle sample.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state      <= IDLE;
      run        <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      exp_byte   <= 8'h00;
      sample_cnt <= 16'h0000;
    end else begin
      err_pulse <= 1'b0;
      if (in_vld) begin
        case (state)
          IDLE: begin
            exp_byte   <= nxt_byte;
            run        <= '0;
            state      <= SYNC;
            sample_cnt <= sample_cnt + 16'd1;
          end
          SYNC: begin
            exp_byte   <= nxt_byte;
            sample_cnt <= sample_cnt + 16'd1;
            if (match) begin
              run <= run + RUN_W'(1);
              if (run + RUN_W'(1) == LOCK_RUN) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCK: begin
            sample_cnt <= sample_cnt + 16'd1;
            if (match) begin
              exp_byte <= nxt_byte;
            end else begin
              err_pulse <= 1'b1;
              locked    <= 1'b0;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
`ifdef BYTE_SEQ_CHECKER_HALT_EN
              state <= HALT;
`else
              // Reseed from the offending byte so a shifted stream can relock.
              exp_byte <= nxt_byte;
              run      <= '0;
              state    <= SYNC;
`endif
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_seq_checker.sv
// Directed table-driven bench for byte_seq_checker (STEP=1, LOCK_CNT=2), plus a narrow-counter instance.
module tb_byte_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_vld, a_clr, b_vld, b_clr;
  logic [7:0]  a_byte, b_byte;
  logic        a_locked, a_err, b_locked, b_err;
  logic [7:0]  a_cnt, a_exp, b_exp;
  logic [1:0]  b_cnt;
  logic [15:0] a_samp, b_samp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_seq_checker #(.STEP(1), .LOCK_CNT(2), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(a_vld), .in_byte(a_byte), .clr(a_clr),
    .locked(a_locked), .err_pulse(a_err), .err_cnt(a_cnt), .exp_byte(a_exp),
    .sample_cnt(a_samp));

  byte_seq_checker #(.STEP(1), .LOCK_CNT(2), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(b_vld), .in_byte(b_byte), .clr(b_clr),
    .locked(b_locked), .err_pulse(b_err), .err_cnt(b_cnt), .exp_byte(b_exp),
    .sample_cnt(b_samp));

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  byt;
    logic        locked;
    logic        err;
    logic [7:0]  cnt;
    logic [7:0]  exp;
    logic [15:0] samp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step_a(input logic c, input logic v, input logic [7:0] b);
    @(negedge clk);
    a_clr = c; a_vld = v; a_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [7:0] b);
    @(negedge clk);
    b_clr = 1'b0; b_vld = v; b_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic l, input logic e, input logic [7:0] c,
                       input logic [7:0] x, input logic [15:0] s);
    chk({tag, ".locked"}, 32'(a_locked), 32'(l));
    chk({tag, ".err_pulse"}, 32'(a_err), 32'(e));
    chk({tag, ".err_cnt"}, 32'(a_cnt), 32'(c));
    chk({tag, ".exp_byte"}, 32'(a_exp), 32'(x));
    chk({tag, ".sample_cnt"}, 32'(a_samp), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0; a_vld = 1'b1; a_byte = 8'h55;
    b_clr = 1'b0; b_vld = 1'b0; b_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 1'b0, 1'b0, 8'h00, 8'h00, 16'd0);
    chk("reset.b_err_cnt", 32'(b_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; a_vld = 1'b0;

    // seed and lock, idle gaps, clr mid-stream, SYNC mismatches, wrap
    vq.push_back('{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h06, 16'd1});
    vq.push_back('{1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 8'h07, 16'd2});
    vq.push_back('{1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 8'h00, 8'h08, 16'd3});
    vq.push_back('{1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 8'h08, 16'd3});
    vq.push_back('{1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 8'h08, 16'd3});
    vq.push_back('{1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 8'h09, 16'd4});
    vq.push_back('{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0});
    vq.push_back('{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 8'h42, 16'd1});
    vq.push_back('{1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 8'h43, 16'd2});
    vq.push_back('{1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 8'h31, 16'd3});
    vq.push_back('{1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 8'h32, 16'd4});
    vq.push_back('{1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 8'h00, 8'hFD, 16'd5});
    vq.push_back('{1'b0, 1'b1, 8'hFD, 1'b0, 1'b0, 8'h00, 8'hFE, 16'd6});
    vq.push_back('{1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 8'hFF, 16'd7});
    vq.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 16'd8});
    vq.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h01, 16'd9});
    vq.push_back('{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h02, 16'd10});

    for (int i = 0; i < vq.size(); i++) begin
      step_a(vq[i].clr, vq[i].vld, vq[i].byt);
      chk_a($sformatf("vec%0d", i), vq[i].locked, vq[i].err, vq[i].cnt, vq[i].exp, vq[i].samp);
    end

    // break while locked: 0x0F seeds, 0x10/0x11 lock, 0x20 breaks
    step_a(1'b1, 1'b0, 8'h00);
    step_a(1'b0, 1'b1, 8'h0F);
    step_a(1'b0, 1'b1, 8'h10);
    step_a(1'b0, 1'b1, 8'h11);
    chk_a("brk.lock", 1'b1, 1'b0, 8'h00, 8'h12, 16'd3);
    step_a(1'b0, 1'b1, 8'h20);
`ifdef BYTE_SEQ_CHECKER_HALT_EN
    chk_a("brk.hit", 1'b0, 1'b1, 8'h01, 8'h12, 16'd4);
    step_a(1'b0, 1'b1, 8'h21);
    chk_a("brk.halt1", 1'b0, 1'b0, 8'h01, 8'h12, 16'd4);
    step_a(1'b0, 1'b1, 8'h12);
    step_a(1'b0, 1'b1, 8'h13);
    chk_a("brk.halt2", 1'b0, 1'b0, 8'h01, 8'h12, 16'd4);
    step_a(1'b1, 1'b0, 8'h00);
    chk_a("brk.clr", 1'b0, 1'b0, 8'h00, 8'h00, 16'd0);
    step_a(1'b0, 1'b1, 8'h41);
    chk_a("brk.reseed", 1'b0, 1'b0, 8'h00, 8'h42, 16'd1);
`else
    chk_a("brk.hit", 1'b0, 1'b1, 8'h01, 8'h21, 16'd4);
    step_a(1'b0, 1'b1, 8'h21);
    chk_a("brk.pulse_end", 1'b0, 1'b0, 8'h01, 8'h22, 16'd5);
    step_a(1'b0, 1'b1, 8'h22);
    chk_a("brk.relock", 1'b1, 1'b0, 8'h01, 8'h23, 16'd6);
    step_a(1'b0, 1'b1, 8'h50);
    step_a(1'b0, 1'b1, 8'h60);
    chk_a("brk.back2back", 1'b0, 1'b0, 8'h02, 8'h61, 16'd8);
`endif

    // narrow error counter: repeated lock/break episodes on dut_b
`ifdef BYTE_SEQ_CHECKER_HALT_EN
    for (int k = 0; k < 3; k++) begin
      step_b(1'b1, 8'h80); step_b(1'b1, 8'h81); step_b(1'b1, 8'h82);
    end
    chk("halt.b_err_cnt", 32'(b_cnt), 32'd1);
    chk("halt.b_sample_cnt", 32'(b_samp), 32'd4);
`else
    for (int k = 0; k < 6; k++) begin
      step_b(1'b1, 8'h80);
      chk($sformatf("sat.ep%0d", k), 32'(b_cnt), (k > 3) ? 32'd3 : 32'(k));
      step_b(1'b1, 8'h81);
      step_b(1'b1, 8'h82);
      chk($sformatf("sat.lock%0d", k), 32'(b_locked), 32'd1);
    end
    step_b(1'b1, 8'h00);
    chk("sat.hold_pulse", 32'(b_err), 32'd1);
    chk("sat.hold_cnt", 32'(b_cnt), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
